// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte on valid/ready, times its own baud
// and serialises start, 8 data bits LSB first, optional parity and 1-2 stops.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    output logic [7:0] par_data,
    input  logic       par_bit,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] state_dbg
);

    // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE and tx_valid is ignored otherwise.
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      data_q, data_n;
    logic            par_en_q, par_en_n;
    logic            odd_q, odd_n;
    logic            stop2_q, stop2_n;
    logic            tx_out_q, tx_out_n;
    logic            ready_q, ready_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            bit_end;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            data_q   <= 8'h00;
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
            stop2_q  <= 1'b0;
            tx_out_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            data_q   <= data_n;
            par_en_q <= par_en_n;
            odd_q    <= odd_n;
            stop2_q  <= stop2_n;
            tx_out_q <= tx_out_n;
            ready_q  <= ready_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        data_n   = data_q;
        par_en_n = par_en_q;
        odd_n    = odd_q;
        stop2_n  = stop2_q;
        bit_end  = (cnt == LAST);

        if (state == S_IDLE) begin
            if (tx_valid && ready_q) begin
                data_n   = tx_data;
                par_en_n = ^parity_type;
                odd_n    = (parity_type == 2'b01);
                stop2_n  = stop_bits;
                state_n  = S_START;
                cnt_n    = '0;
                idx_n    = '0;
            end
        end else if (!bit_end) begin
            cnt_n = cnt + 1'b1;
        end else begin
            cnt_n = '0;
            case (state)
                S_START: begin
                    state_n = S_DATA;
                    idx_n   = '0;
                end
                S_DATA: begin
                    if (idx == 3'd7) begin
                        idx_n   = '0;
                        state_n = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    state_n = S_STOP;
                    idx_n   = '0;
                end
                S_STOP: begin
                    if (idx == {2'b00, stop2_q}) begin
                        state_n = S_IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state, so they line up with the
    // state register; the parity bit is captured once when PARITY is entered.
    always_comb begin
        tx_out_n = 1'b1;
        case (state_n)
            S_START:  tx_out_n = 1'b0;
            S_DATA:   tx_out_n = data_n[idx_n];
            S_PARITY: tx_out_n = (state == S_PARITY) ? tx_out_q : (par_bit ^ odd_q);
            default:  tx_out_n = 1'b1;
        endcase
        ready_n = (state_n == S_IDLE);
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_n == S_STOP) && (idx_n == {2'b00, stop2_n}) && (cnt_n == LAST);
    end

    assign tx_out    = tx_out_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign par_data  = data_q;
    assign state_dbg = state;

endmodule
